// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: default widths, the minimum
// legal oversampling ratio and the three-sample majority vote.
package uart_rx_pkg;

    localparam int PRESCALE_W   = 6;
    localparam int BIT_CNT_W    = 4;
    localparam int MIN_PRESCALE = 6;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_edge_bit_counter.sv
// Oversampling edge counter and frame bit counter with a one-cycle
// frame-done pulse on the wrap that follows the last edge of the last bit.
module uart_edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = uart_rx_pkg::PRESCALE_W,
    parameter int BIT_CNT_W  = uart_rx_pkg::BIT_CNT_W
) (
    input  logic                  clk_sys,
    input  logic                  rst_b,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [BIT_CNT_W-1:0]  frame_bits,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  frame_done
);

    logic [PRESCALE_W-1:0] edge_last;
    logic [BIT_CNT_W-1:0]  bit_last;
    logic                  edge_wrap;
    logic                  bit_wrap;

    // Greater-or-equal so a prescale shrink below the current edge wraps at once.
    assign edge_last = prescale - PRESCALE_W'(1);
    assign bit_last  = frame_bits - BIT_CNT_W'(1);
    assign edge_wrap = (edge_cnt >= edge_last);
    assign bit_wrap  = (bit_cnt >= bit_last);

    always_ff @(posedge clk_sys) begin
        if (!rst_b) begin
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            frame_done <= 1'b0;
        end else if (!en) begin
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (edge_wrap) begin
                edge_cnt <= '0;
                if (bit_wrap) begin
                    bit_cnt    <= '0;
                    frame_done <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                end
            end else begin
                edge_cnt <= edge_cnt + PRESCALE_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receive oversampling front end: three samples around mid-bit, majority
// vote registered into Samp_sample with a one-cycle Samp_Sample_Valid strobe.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = uart_rx_pkg::PRESCALE_W,
    parameter int BIT_CNT_W  = uart_rx_pkg::BIT_CNT_W
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Samp_EN,
    input  logic                  Samp_RX_IN,
    input  logic [PRESCALE_W-1:0] Samp_Prescale,
    input  logic [BIT_CNT_W-1:0]  Samp_Frame_Bits,
    output logic                  Samp_sample,
    output logic                  Samp_Sample_Valid,
    output logic [PRESCALE_W-1:0] Samp_Edge_Cnt,
    output logic [BIT_CNT_W-1:0]  Samp_Bit_Cnt,
    output logic                  Samp_Frame_Done
);

    logic [PRESCALE_W-1:0] mid;
    logic [PRESCALE_W-1:0] mid_before;
    logic [PRESCALE_W-1:0] mid_after;
    logic                  prescale_ok;
    logic                  samp_first;
    logic                  samp_second;

    uart_edge_bit_counter #(
        .PRESCALE_W (PRESCALE_W),
        .BIT_CNT_W  (BIT_CNT_W)
    ) u_counter (
        .clk_sys    (CLK),
        .rst_b      (RST),
        .en         (Samp_EN),
        .prescale   (Samp_Prescale),
        .frame_bits (Samp_Frame_Bits),
        .edge_cnt   (Samp_Edge_Cnt),
        .bit_cnt    (Samp_Bit_Cnt),
        .frame_done (Samp_Frame_Done)
    );

    assign mid         = Samp_Prescale >> 1;
    assign mid_before  = mid - PRESCALE_W'(1);
    assign mid_after   = mid + PRESCALE_W'(1);
    assign prescale_ok = !Samp_Prescale[0] && (Samp_Prescale >= PRESCALE_W'(MIN_PRESCALE));

    // Samp_sample is deliberately left out of the enable clear so the last
    // voted bit stays visible to the checkers after the FSM drops enable.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            samp_first        <= 1'b0;
            samp_second       <= 1'b0;
            Samp_sample       <= 1'b0;
            Samp_Sample_Valid <= 1'b0;
        end else if (!Samp_EN) begin
            samp_first        <= 1'b0;
            samp_second       <= 1'b0;
            Samp_Sample_Valid <= 1'b0;
        end else begin
            Samp_Sample_Valid <= 1'b0;
            if (Samp_Edge_Cnt == mid_before) begin
                samp_first <= Samp_RX_IN;
            end
            if (Samp_Edge_Cnt == mid) begin
                samp_second <= Samp_RX_IN;
            end
            if ((Samp_Edge_Cnt == mid_after) && prescale_ok) begin
                Samp_sample       <= majority3(samp_first, samp_second, Samp_RX_IN);
                Samp_Sample_Valid <= 1'b1;
            end
        end
    end

endmodule

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

Oversampling front end of the UART receiver. It sits between the synchronized serial line and the receive-side checkers (start check, parity check, stop check, deserializer). It counts oversampling edges and bit positions within a frame, and takes three samples around the middle of each bit. It then delivers a majority-voted bit with a one-cycle valid strobe, which the start checker consumes as its sample/valid pair.

## Interface
Parameters:
- PRESCALE_W, default 6: width of the prescale and edge counter; supports ratios up to 2^PRESCALE_W − 2.
- BIT_CNT_W, default 4: width of the frame-bit counter.

Ports:
- CLK, input, 1: single clock; one oversampling tick per cycle.
- RST, input, 1: reset, synchronous, active-low.
- Samp_EN, input, 1: enable from the RX FSM; counters run only while high.
- Samp_RX_IN, input, 1: serial line, already synchronized to CLK.
- Samp_Prescale, input, PRESCALE_W: oversampling ratio; must be even and ≥ 6 (8/16/32 are the normal values).
- Samp_Frame_Bits, input, BIT_CNT_W: bits per frame including start, parity and stop (10 or 11 typical); must be ≥ 1.
- Samp_sample, output, 1: majority-voted bit value.
- Samp_Sample_Valid, output, 1: one-cycle strobe qualifying Samp_sample.
- Samp_Edge_Cnt, output, PRESCALE_W: current oversampling edge within the bit.
- Samp_Bit_Cnt, output, BIT_CNT_W: current bit index within the frame.
- Samp_Frame_Done, output, 1: one-cycle pulse after the last edge of the last bit.

## Operation
- Reset (RST low at a clock edge): all outputs and internal registers are 0 on the following cycle.
- Samp_EN low: the edge counter, bit counter, sample registers, Samp_Sample_Valid and Samp_Frame_Done clear on the next clock. Samp_sample holds its last value.
- Edge counter, while Samp_EN is high:
  - It increments every clock.
  - When Samp_Edge_Cnt ≥ Samp_Prescale−1, it wraps to 0. The ≥ compare makes a mid-frame prescale decrease recover within one cycle.
- Bit counter:
  - It increments on each edge wrap.
  - On a wrap with Samp_Bit_Cnt ≥ Samp_Frame_Bits−1, it wraps to 0 and Samp_Frame_Done pulses.
- Sampling, with mid = Samp_Prescale >> 1:
  - Samp_RX_IN is captured at the clock edges where Samp_Edge_Cnt equals mid−1 and mid.
  - At the edge where Samp_Edge_Cnt equals mid+1, the majority of the two captured values and the live Samp_RX_IN is registered into Samp_sample, and Samp_Sample_Valid is set for exactly one cycle.
- Majority rule: output 1 if at least two of the three samples are 1.
- Illegal prescale (odd, or < 6): counters still run, but Samp_Sample_Valid never asserts. No other error reporting.
- Samp_EN falling on the same edge a strobe or pulse would be set: Samp_EN wins, so no strobe and no pulse.
- Samp_Prescale and Samp_Frame_Bits are sampled live every cycle. No shadow registers.

## Timing
- Samp_Sample_Valid is high during the cycle where Samp_Edge_Cnt = mid+2. Examples: edge 6 for prescale 8, edge 10 for prescale 16. It is always inside the same bit period.
- Latency is 1 cycle from the third sample to the valid strobe.
- Samp_Frame_Done is high during the cycle where Samp_Edge_Cnt = 0 and Samp_Bit_Cnt = 0 following the frame's last bit. The last bit's valid strobe always precedes it.
- With Samp_EN high for the first time, Samp_Edge_Cnt reads 0 in the first enabled cycle and 1 in the next.
- The first bit's strobe occurs mid+2 cycles after Samp_EN rises.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package uart_rx_pkg holds:
  - MIN_PRESCALE = 6.
  - A majority3 function.
  - Default widths PRESCALE_W and BIT_CNT_W, reused by the deserializer and the parity/stop checkers.
- One sub-module, uart_edge_bit_counter, containing both counters and the Frame_Done pulse generation. The sampler/voter logic lives in the top module.

## Test plan
- Prescale 8, frame 10, Samp_RX_IN held 0, Samp_EN raised -> valid with sample 0 at Samp_Edge_Cnt = 6 of bit 0; ten strobes total; Frame_Done one cycle at Edge 0 / Bit 0 after 80 cycles.
- Prescale 16, Samp_RX_IN = 1 only at Samp_Edge_Cnt = 8 (single-cycle glitch) -> strobe at Samp_Edge_Cnt = 10 with sample 0. Same bench with RX = 1 at edges 8 and 9 -> sample 1.
- Samp_EN dropped on the cycle where Samp_Edge_Cnt = 9, prescale 16 -> no strobe; both counters read 0 on the next cycle.
- RST low at bit 3, edge 5 -> all outputs 0 on the next cycle. After release with EN high, counting restarts from edge 0, bit 0.
- Prescale changed from 32 to 8 while Samp_Edge_Cnt = 20 -> counter wraps to 0 on the next cycle and the bit counter increments once.
- Prescale 5 (illegal) -> counters wrap at 4; Samp_Sample_Valid stays 0 for an entire frame.
